// File: rtl/mem_port_router_pkg.sv
// rtl/mem_port_router_pkg.sv - shared types and helpers for the data-side memory port router
package MemRouterStruct;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   // Index wide enough for the largest supported port count (8).
   localparam int MAX_PORTS  = 8;
   localparam int PORT_IDX_W = (MAX_PORTS > 1) ? $clog2(MAX_PORTS) : 1;
   typedef logic [PORT_IDX_W-1:0] port_idx_t;

   // LSB of slice idx inside a flattened vector of width-bit fields.
   function automatic int region_lsb(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/mem_router_decode.sv
// rtl/mem_router_decode.sv - combinational base/mask address decoder, lowest index wins
module mem_router_decode
   import MemRouterStruct::*;
#(
   parameter int ADDR_WIDTH = 64,
   parameter int NUM_PORTS  = 3,
   parameter logic [NUM_PORTS*ADDR_WIDTH-1:0] REGION_BASE = '0,
   parameter logic [NUM_PORTS*ADDR_WIDTH-1:0] REGION_MASK = '0
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic                  hit,
   output port_idx_t             idx
);

   // Walk from the top index down so the lowest hitting region is assigned last.
   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if ((addr & REGION_MASK[region_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH]) ==
             REGION_BASE[region_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH]) begin
            hit = 1'b1;
            idx = port_idx_t'(i);
         end
      end
   end

endmodule

// File: rtl/mem_port_router.sv
// rtl/mem_port_router.sv - routes one core data request to a downstream port; MEM_ROUTER_TIMEOUT_EN adds a WAIT timeout
module mem_port_router
   import MemRouterStruct::*;
#(
   parameter int ADDR_WIDTH     = 64,
   parameter int DATA_WIDTH     = 64,
   parameter int NUM_PORTS      = 3,
   parameter logic [NUM_PORTS*ADDR_WIDTH-1:0] REGION_BASE = '0,
   parameter logic [NUM_PORTS*ADDR_WIDTH-1:0] REGION_MASK = '0,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            cpu_ren,
   input  logic                            cpu_wen,
   input  logic [ADDR_WIDTH-1:0]           cpu_addr,
   input  logic [DATA_WIDTH-1:0]           cpu_wdata,
   input  logic [DATA_WIDTH/8-1:0]         cpu_wmask,
   output logic                            cpu_stall,
   output logic [DATA_WIDTH-1:0]           cpu_rdata,
   output logic                            cpu_err,
   output logic [NUM_PORTS-1:0]            port_req,
   output logic                            port_we,
   output logic [ADDR_WIDTH-1:0]           port_addr,
   output logic [DATA_WIDTH-1:0]           port_wdata,
   output logic [DATA_WIDTH/8-1:0]         port_wmask,
   input  logic [NUM_PORTS-1:0]            port_done,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_rdata,
   input  logic [NUM_PORTS-1:0]            port_err
);

   state_t                 state;
   state_t                 state_next;
   logic                   cpu_req;
   logic                   dec_hit;
   port_idx_t              dec_idx;
   logic [NUM_PORTS-1:0]   sel_oh;
   logic                   done_sel;
   logic                   err_sel;
   logic [DATA_WIDTH-1:0]  rdata_sel;
   logic                   timed_out;

   assign cpu_req = cpu_ren | cpu_wen;

   mem_router_decode #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .NUM_PORTS   (NUM_PORTS),
      .REGION_BASE (REGION_BASE),
      .REGION_MASK (REGION_MASK)
   ) u_decode (
      .addr (cpu_addr),
      .hit  (dec_hit),
      .idx  (dec_idx)
   );

   // The selected port is held one-hot so completion filtering is a simple AND.
   assign done_sel = |(port_done & sel_oh);
   assign err_sel  = |(port_err & sel_oh);

   always_comb begin
      rdata_sel = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (sel_oh[i]) begin
            rdata_sel = rdata_sel | port_rdata[region_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
         end
      end
   end

`ifdef MEM_ROUTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CNT_W-1:0] wait_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (state == ISSUE) begin
         wait_cnt <= '0;
      end else if (state == WAIT) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   assign timed_out = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign timed_out = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (cpu_req) state_next = dec_hit ? ISSUE : DONE;
         ISSUE:   state_next = WAIT;
         WAIT:    if (done_sel || timed_out) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      cpu_stall = 1'b0;
      port_req  = '0;
      case (state)
         IDLE:    cpu_stall = cpu_req;
         ISSUE: begin
            cpu_stall = 1'b1;
            port_req  = sel_oh;
         end
         WAIT:    cpu_stall = 1'b1;
         DONE:    cpu_stall = 1'b0;
         default: cpu_stall = 1'b0;
      endcase
   end

   // Request capture and response registers; a completion in the timeout cycle takes priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         port_we    <= 1'b0;
         port_addr  <= '0;
         port_wdata <= '0;
         port_wmask <= '0;
         sel_oh     <= '0;
         cpu_rdata  <= '0;
         cpu_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cpu_req) begin
                  port_we    <= cpu_wen;
                  port_addr  <= cpu_addr;
                  port_wdata <= cpu_wdata;
                  port_wmask <= cpu_wmask;
                  sel_oh     <= dec_hit ? (NUM_PORTS'(1) << dec_idx) : '0;
                  if (!dec_hit) begin
                     cpu_rdata <= '0;
                     cpu_err   <= 1'b1;
                  end
               end
            end
            WAIT: begin
               if (done_sel) begin
                  cpu_rdata <= rdata_sel;
                  cpu_err   <= err_sel;
               end else if (timed_out) begin
                  cpu_rdata <= '0;
                  cpu_err   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_router.sv
// tb/tb_mem_port_router.sv - scoreboard bench for mem_port_router (timeout cases under MEM_ROUTER_TIMEOUT_EN)
module tb_mem_port_router;

   localparam logic [63:0] MSK = 64'hFFFF_FFFF_8000_0000;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         cpu_ren = 1'b0;
   logic         cpu_wen = 1'b0;
   logic [63:0]  cpu_addr = '0;
   logic [63:0]  cpu_wdata = '0;
   logic [7:0]   cpu_wmask = '0;
   logic         cpu_stall;
   logic [63:0]  cpu_rdata;
   logic         cpu_err;
   logic [2:0]   port_req;
   logic         port_we;
   logic [63:0]  port_addr;
   logic [63:0]  port_wdata;
   logic [7:0]   port_wmask;
   logic [2:0]   port_done = '0;
   logic [191:0] port_rdata = '0;
   logic [2:0]   port_err = '0;

   mem_port_router #(
      .ADDR_WIDTH     (64),
      .DATA_WIDTH     (64),
      .NUM_PORTS      (3),
      .REGION_BASE    ({64'h0000_0000_0000_4000, 64'h0000_0000_8000_0000, 64'h0}),
      .REGION_MASK    ({64'hFFFF_FFFF_FFFF_F000, MSK, MSK}),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_ren    (cpu_ren),
      .cpu_wen    (cpu_wen),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_wmask  (cpu_wmask),
      .cpu_stall  (cpu_stall),
      .cpu_rdata  (cpu_rdata),
      .cpu_err    (cpu_err),
      .port_req   (port_req),
      .port_we    (port_we),
      .port_addr  (port_addr),
      .port_wdata (port_wdata),
      .port_wmask (port_wmask),
      .port_done  (port_done),
      .port_rdata (port_rdata),
      .port_err   (port_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  req;
      logic        we;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [7:0]  wmask;
   } req_exp_t;

   typedef struct {
      logic [63:0] rdata;
      logic        err;
      int          lat;
      logic [63:0] wdata;
   } rsp_exp_t;

   req_exp_t req_q[$];
   rsp_exp_t rsp_q[$];
   int       cyc = 0;
   int       t0 = 0;
   int       errors = 0;
   int       checks = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: samples just after each rising edge and pops expectations when the DUT presents output.
   initial begin
      req_exp_t re;
      rsp_exp_t rs;
      forever begin
         @(posedge clk);
         #1;
         if (!rst) begin
            if (port_req != 3'b000) begin
               if (req_q.size() == 0) begin
                  check("unexpected_port_req", 64'(port_req), 64'd0);
               end else begin
                  re = req_q.pop_front();
                  check("port_req", 64'(port_req), 64'(re.req));
                  check("req_cycle", 64'(cyc - t0), 64'd1);
                  check("port_we", 64'(port_we), 64'(re.we));
                  check("port_addr", port_addr, re.addr);
                  check("port_wdata", port_wdata, re.wdata);
                  check("port_wmask", 64'(port_wmask), 64'(re.wmask));
               end
            end
            if ((cpu_ren || cpu_wen) && !cpu_stall) begin
               if (rsp_q.size() == 0) begin
                  check("unexpected_rsp", 64'(rsp_q.size()), 64'd1);
               end else begin
                  rs = rsp_q.pop_front();
                  check("cpu_rdata", cpu_rdata, rs.rdata);
                  check("cpu_err", 64'(cpu_err), 64'(rs.err));
                  check("latency", 64'(cyc - t0), 64'(rs.lat));
                  check("latched_wdata", port_wdata, rs.wdata);
               end
            end
         end
      end
   end

   // port < 0 means the address is expected to be unmapped; noise adds ignored done pulses.
   task automatic do_txn(input logic wen_i, input logic ren_i, input logic [63:0] addr_i,
                         input logic [63:0] wdata_i, input logic [7:0] wmask_i,
                         input int port, input int done_at, input logic [63:0] resp_rdata,
                         input logic resp_err, input bit noise, input int exp_lat,
                         input logic [63:0] exp_rdata, input logic exp_err);
      req_exp_t re;
      rsp_exp_t rs;
      bit finished;
      int other;
      finished = 1'b0;
      @(negedge clk);
      cpu_ren = ren_i;
      cpu_wen = wen_i;
      cpu_addr = addr_i;
      cpu_wdata = wdata_i;
      cpu_wmask = wmask_i;
      t0 = cyc;
      if (port >= 0) begin
         re.req = 3'b001 << port;
         re.we = wen_i;
         re.addr = addr_i;
         re.wdata = wdata_i;
         re.wmask = wmask_i;
         req_q.push_back(re);
      end
      rs.rdata = exp_rdata;
      rs.err = exp_err;
      rs.lat = exp_lat;
      rs.wdata = wdata_i;
      rsp_q.push_back(rs);
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         port_done = '0;
         port_err = '0;
         port_rdata = '0;
         if (cyc == t0 + 1) cpu_wdata = ~wdata_i;
         if (port >= 0) begin
            if (cyc == t0 + done_at) begin
               port_done[port] = 1'b1;
               port_err[port] = resp_err;
               port_rdata[port*64 +: 64] = resp_rdata;
            end
            if (noise && cyc == t0 + 1) begin
               port_done[port] = 1'b1;
               port_rdata[port*64 +: 64] = 64'hBAD0_BAD0_BAD0_0001;
            end
            if (noise && cyc == t0 + 2) begin
               other = (port + 1) % 3;
               port_done[other] = 1'b1;
               port_err[other] = 1'b1;
               port_rdata[other*64 +: 64] = 64'hBAD0_BAD0_BAD0_0002;
            end
         end
         if (!cpu_stall) begin
            finished = 1'b1;
            break;
         end
      end
      if (!finished) check("txn_timeout", 64'(cpu_stall), 64'd0);
      cpu_ren = 1'b0;
      cpu_wen = 1'b0;
      port_done = '0;
      port_err = '0;
      port_rdata = '0;
      @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_stall", 64'(cpu_stall), 64'd0);
      check("rst_port_req", 64'(port_req), 64'd0);
      check("rst_rdata", cpu_rdata, 64'd0);
      check("rst_err", 64'(cpu_err), 64'd0);
      check("rst_port_we", 64'(port_we), 64'd0);
      check("rst_port_addr", port_addr, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Read port1, done in cycle 4, stall low in cycle 5.
      do_txn(1'b0, 1'b1, 64'h8000_0010, 64'h0, 8'h00, 1, 4, 64'hDEADBEEF_CAFEF00D, 1'b0, 1'b0,
             5, 64'hDEADBEEF_CAFEF00D, 1'b0);
      // Write port0, cpu_wdata disturbed in cycle 1.
      do_txn(1'b1, 1'b0, 64'h100, 64'h11223344_55667788, 8'h0F, 0, 2, 64'h0, 1'b0, 1'b0,
             3, 64'h0, 1'b0);
      // Unmapped read.
      do_txn(1'b0, 1'b1, 64'hFFFF_0000_0000_0000, 64'h0, 8'h00, -1, 0, 64'h0, 1'b0, 1'b0,
             1, 64'h0, 1'b1);
      // Overlap: port0 wins; early and wrong-index done pulses are ignored.
      do_txn(1'b0, 1'b1, 64'h4000, 64'h0, 8'h00, 0, 3, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0, 1'b1,
             4, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0);
      // Read and write together: write wins.
      do_txn(1'b1, 1'b1, 64'h8000_0100, 64'h0102_0304_0506_0708, 8'hFF, 1, 2, 64'h77, 1'b0, 1'b0,
             3, 64'h77, 1'b0);
      // Slave error propagates.
      do_txn(1'b0, 1'b1, 64'h7000_0000, 64'h0, 8'h00, 0, 2, 64'h1234_5678, 1'b1, 1'b0,
             3, 64'h1234_5678, 1'b1);

      // Reset while in WAIT, then a late done must be ignored.
      @(negedge clk);
      cpu_ren = 1'b1;
      cpu_addr = 64'h8000_0010;
      cpu_wdata = 64'h0;
      cpu_wmask = 8'h00;
      t0 = cyc;
      req_q.push_back('{req: 3'b010, we: 1'b0, addr: 64'h8000_0010, wdata: 64'h0, wmask: 8'h00});
      repeat (3) @(negedge clk);
      rst = 1'b1;
      cpu_ren = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      port_done[1] = 1'b1;
      port_rdata[127:64] = 64'h5555_5555_5555_5555;
      @(negedge clk);
      port_done = '0;
      port_rdata = '0;
      @(negedge clk);
      check("abort_stall", 64'(cpu_stall), 64'd0);
      check("abort_port_req", 64'(port_req), 64'd0);
      check("abort_rdata", cpu_rdata, 64'd0);
      check("abort_err", 64'(cpu_err), 64'd0);

`ifdef MEM_ROUTER_TIMEOUT_EN
      do_txn(1'b0, 1'b1, 64'h8000_0020, 64'h0, 8'h00, 1, -1000, 64'h0, 1'b0, 1'b0,
             18, 64'h0, 1'b1);
      do_txn(1'b0, 1'b1, 64'h8000_0020, 64'h0, 8'h00, 1, 17, 64'hFEED_0000_0000_BEEF, 1'b0, 1'b0,
             18, 64'hFEED_0000_0000_BEEF, 1'b0);
`else
      do_txn(1'b0, 1'b1, 64'h8000_0020, 64'h0, 8'h00, 1, 40, 64'hFEED_0000_0000_BEEF, 1'b0, 1'b0,
             41, 64'hFEED_0000_0000_BEEF, 1'b0);
`endif

      repeat (3) @(negedge clk);
      check("req_q_drained", 64'(req_q.size()), 64'd0);
      check("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
